mt_fetch_buf: RTL and testbench

Fetch-stage instruction buffer of the barrel pipeline: sits directly downstream of the per-thread PC unit and upstream of decode. Accepts a (pc, tid) pair per cycle and issues it to a fixed 1-cycle-latency instruction memory. Queues the returned instruction with its pc/tid in a small FIFO toward decode. Squashes every in-flight or buffered fetch of a thread whose branch resolves taken in EX.

---
 rtl/mt_fetch_buf.sv | 131 +++++++++++++
 tb/tb_mt_fetch_buf.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mt_fetch_buf.sv
// Fetch-stage instruction buffer: issues accepted (pc, tid) requests to a 1-cycle imem,
// queues returned instructions toward decode, and squashes fetches of threads whose branch resolves taken.
module mt_fetch_buf #(
    parameter int unsigned NUM_THREADS   = 8,
    parameter int unsigned BITS_THREADS  = $clog2(NUM_THREADS),
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [BITS_THREADS-1:0]  tid_f,
    input  logic                     pc_valid_f,
    output logic                     pc_ready_f,
    output logic                     imem_en,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     pc_src_e,
    input  logic [BITS_THREADS-1:0]  branch_tid_e,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [BITS_THREADS-1:0]  tid_d,
    output logic                     valid_d,
    input  logic                     ready_d
);

    localparam int unsigned CW = $clog2(DEPTH + 2);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0]    instr_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_q    [DEPTH];
    logic [BITS_THREADS-1:0]  tid_q   [DEPTH];
    logic [DEPTH-1:0]         kill_q;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] occ;

    logic                     inflight;
    logic                     inflight_kill;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;
    logic [BITS_THREADS-1:0]  inflight_tid;

    logic acc;
    logic push;
    logic pop;
    logic nonempty;
    logic head_kill;
    logic flush_fetch;
    logic flush_inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    // Accept/flow control; ready_d -> pop -> pc_ready_f is the combinational critical path.
    always_comb begin
        nonempty       = (count != '0);
        head_kill      = kill_q[rd_ptr];
        valid_d        = nonempty & ~head_kill;
        pop            = (valid_d & ready_d) | (nonempty & head_kill);
        push           = inflight;
        occ            = CW'(count + CW'(inflight) - CW'(pop));
        pc_ready_f     = (occ < CW'(DEPTH));
        acc            = pc_valid_f & pc_ready_f;
        imem_en        = acc;
        imem_addr      = pc_f;
        flush_fetch    = pc_src_e & (branch_tid_e == tid_f);
        flush_inflight = pc_src_e & (branch_tid_e == inflight_tid);
        instr_d        = instr_q[rd_ptr];
        pc_d           = pc_q[rd_ptr];
        tid_d          = tid_q[rd_ptr];
    end

    // Single in-flight slot covering the imem read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight      <= 1'b0;
            inflight_kill <= 1'b0;
            inflight_pc   <= '0;
            inflight_tid  <= '0;
        end else begin
            inflight <= acc;
            if (acc) begin
                inflight_kill <= flush_fetch;
                inflight_pc   <= pc_f;
                inflight_tid  <= tid_f;
            end
        end
    end

    // FIFO storage; flush marks matching entries so they drain without reaching decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                tid_q[i]   <= '0;
            end
            kill_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && (count == CW'(DEPTH))));
            for (int i = 0; i < DEPTH; i++) begin
                if (pc_src_e && (tid_q[i] == branch_tid_e)) begin
                    kill_q[i] <= 1'b1;
                end
            end
            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= inflight_pc;
                tid_q[wr_ptr]   <= inflight_tid;
                kill_q[wr_ptr]  <= inflight_kill | flush_inflight;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mt_fetch_buf.sv
// Scoreboard bench for mt_fetch_buf: directed fetch streams, backpressure, flushes and async reset.
module tb_mt_fetch_buf;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic [2:0]  tid_f;
    logic        pc_valid_f;
    logic        pc_ready_f;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        pc_src_e;
    logic [2:0]  branch_tid_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [2:0]  tid_d;
    logic        valid_d;
    logic        ready_d;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  tid;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    mt_fetch_buf #(
        .NUM_THREADS(8), .BITS_THREADS(3), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .tid_f(tid_f), .pc_valid_f(pc_valid_f),
        .pc_ready_f(pc_ready_f), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_src_e(pc_src_e), .branch_tid_e(branch_tid_e),
        .instr_d(instr_d), .pc_d(pc_d), .tid_d(tid_d), .valid_d(valid_d), .ready_d(ready_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    // 1-cycle instruction memory model
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= instr_of(imem_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every consumed head must match the oldest expected fetch
    always @(negedge clk) begin
        if (rst && valid_d && ready_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual pc=%0h tid=%0d required none", pc_d, tid_d);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc", 64'(pc_d), 64'(mon_e.pc));
                check("out_tid", 64'(tid_d), 64'(mon_e.tid));
                check("out_instr", 64'(instr_d), 64'(mon_e.instr));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; presents one request until accepted, returns at posedge+1 after acceptance.
    task automatic fetch(input logic [31:0] pc, input logic [2:0] tid, input bit keep);
        bit done;
        exp_t e;
        done = 0;
        pc_f = pc;
        tid_f = tid;
        pc_valid_f = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (pc_ready_f) begin
                done = 1;
                if (keep) begin
                    e.pc = pc;
                    e.tid = tid;
                    e.instr = instr_of(pc);
                    exp_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        pc_valid_f = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout actual=not_accepted required=accepted pc=%0h", pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b0;
        pc_f = '0;
        tid_f = '0;
        pc_valid_f = 1'b0;
        pc_src_e = 1'b0;
        branch_tid_e = '0;
        ready_d = 1'b1;
        imem_rdata = '0;

        // Reset state
        #2;
        check("rst_valid_d", 64'(valid_d), 64'd0);
        check("rst_instr_d", 64'(instr_d), 64'd0);
        check("rst_pc_d", 64'(pc_d), 64'd0);
        check("rst_tid_d", 64'(tid_d), 64'd0);
        check("rst_imem_en", 64'(imem_en), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_pc_ready", 64'(pc_ready_f), 64'd1);
        @(posedge clk);
        #1;

        // Stream tids 0..7 back to back, outputs from cycle 2 without gaps
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                pc_valid_f = 1'b1;
                pc_f = 32'(i) * 32'h100;
                tid_f = 3'(i);
            end else begin
                pc_valid_f = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                check("stream_imem_en", 64'(imem_en), 64'd1);
                check("stream_imem_addr", 64'(imem_addr), 64'(32'(i) * 32'h100));
                check("stream_ready", 64'(pc_ready_f), 64'd1);
                e.pc = 32'(i) * 32'h100;
                e.tid = 3'(i);
                e.instr = instr_of(e.pc);
                exp_q.push_back(e);
            end
            if (i >= 2) begin
                check("stream_valid", 64'(valid_d), 64'd1);
                check("stream_tid", 64'(tid_d), 64'(i - 2));
            end
            @(posedge clk);
            #1;
        end
        step(3);

        // Backpressure: two accepts, then stalled until decode pops
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                ready_d = 1'b0;
                pc_valid_f = 1'b1;
                pc_f = 32'h400 + 32'(i) * 4;
                tid_f = 3'(i);
            end else begin
                ready_d = 1'b1;
                pc_valid_f = 1'b0;
            end
            @(negedge clk);
            if (i < 6) begin
                check("bp_ready", 64'(pc_ready_f), (i < 2) ? 64'd1 : 64'd0);
                if (pc_ready_f) begin
                    e.pc = pc_f;
                    e.tid = tid_f;
                    e.instr = instr_of(pc_f);
                    exp_q.push_back(e);
                end
            end else begin
                check("bp_release_ready", 64'(pc_ready_f), 64'd1);
                check("bp_release_valid", 64'(valid_d), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        step(4);

        // Flush buffered: tid 3 squashed at head, tid 5 survives
        ready_d = 1'b0;
        fetch(32'h300, 3'd3, 1'b0);
        fetch(32'h500, 3'd5, 1'b1);
        step(2);
        pc_src_e = 1'b1;
        branch_tid_e = 3'd3;
        step(1);
        pc_src_e = 1'b0;
        @(negedge clk);
        check("flush_head_valid", 64'(valid_d), 64'd0);
        check("flush_head_tid", 64'(tid_d), 64'd3);
        @(negedge clk);
        check("flush_next_valid", 64'(valid_d), 64'd1);
        check("flush_next_tid", 64'(tid_d), 64'd5);
        @(posedge clk);
        #1 ready_d = 1'b1;
        step(4);

        // Flush at accept and while in flight
        pc_src_e = 1'b1;
        branch_tid_e = 3'd2;
        fetch(32'h2A0, 3'd2, 1'b0);
        pc_src_e = 1'b0;
        fetch(32'h4A0, 3'd4, 1'b1);
        fetch(32'h1B0, 3'd1, 1'b0);
        pc_src_e = 1'b1;
        branch_tid_e = 3'd1;
        fetch(32'h6B0, 3'd6, 1'b1);
        pc_src_e = 1'b0;
        step(5);

        // Non-matching flush leaves buffered entries intact
        ready_d = 1'b0;
        fetch(32'h110, 3'd1, 1'b1);
        fetch(32'h220, 3'd2, 1'b1);
        step(2);
        pc_src_e = 1'b1;
        branch_tid_e = 3'd6;
        step(1);
        pc_src_e = 1'b0;
        @(negedge clk);
        check("nomatch_valid", 64'(valid_d), 64'd1);
        check("nomatch_tid", 64'(tid_d), 64'd1);
        @(posedge clk);
        #1 ready_d = 1'b1;
        step(4);

        // Async reset mid-stream
        fetch(32'h000, 3'd0, 1'b1);
        fetch(32'h010, 3'd1, 1'b1);
        fetch(32'h020, 3'd2, 1'b1);
        fetch(32'h030, 3'd3, 1'b1);
        #1;
        check("prereset_valid", 64'(valid_d), 64'd1);
        check("prereset_tid", 64'(tid_d), 64'd2);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", 64'(valid_d), 64'd0);
        check("arst_pc_d", 64'(pc_d), 64'd0);
        check("arst_ready", 64'(pc_ready_f), 64'd1);
        step(2);
        rst = 1'b1;
        step(1);
        fetch(32'h770, 3'd7, 1'b1);
        step(5);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
